// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: issue/return controller for the M-extension mul/div unit.
// Accepts one request at a time, drives the combinational unit for LATENCY
// cycles, captures the (optionally *W sign-extended) result and holds it
// until write-back takes it.
//
// state  | meaning
// IDLE   | ready for a new request
// BUSY   | op in flight, operands/op lines driven, counter running
// DONE   | result held, out_valid high until out_ready
module mdu_issue_ctrl #(
    parameter int LATENCY = 4,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic             in_word,
    input  logic [63:0]      in_src1,
    input  logic [63:0]      in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             mac_mul,
    output logic             mac_mulh,
    output logic             mac_mulhu,
    output logic             mac_mulhsu,
    output logic             mac_div,
    output logic             mac_divu,
    output logic             mac_rem,
    output logic             mac_remu,
    output logic [63:0]      mac_src1,
    output logic [63:0]      mac_src2,
    input  logic [63:0]      mac_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_op;
    logic [63:0]        r_src1;
    logic [63:0]        r_src2;
    logic [TAG_W-1:0]   r_tag;
    logic               r_word;
    logic               r_illegal;
    logic [63:0]        r_result;

    logic               w_fire;
    logic               w_busy;
    logic               w_last;
    logic               w_illegal;
    logic               w_zext;
    logic [7:0]         w_op;
    logic [63:0]        w_src1;
    logic [63:0]        w_src2;

    assign in_ready  = (r_state == S_IDLE) & ~flush;
    assign w_fire    = in_valid & in_ready;
    assign w_busy    = (r_state == S_BUSY);
    assign w_last    = w_busy & (r_cnt == '0) & ~flush;

    // Request decode: one-hot op bit indexed by funct3, word-form operand conditioning.
    always_comb begin
        w_illegal = in_word & (in_funct3 != 3'b000) & (in_funct3[2] == 1'b0);
        w_op      = w_illegal ? 8'h00 : (8'h01 << in_funct3);
        // divu/remu (101/111) take zero-extended word operands; everything else sign-extends
        w_zext    = in_funct3[2] & in_funct3[0];
        w_src1    = in_src1;
        w_src2    = in_src2;
        if (in_word) begin
            w_src1 = w_zext ? {32'h0, in_src1[31:0]} : {{32{in_src1[31]}}, in_src1[31:0]};
            w_src2 = w_zext ? {32'h0, in_src2[31:0]} : {{32{in_src2[31]}}, in_src2[31:0]};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_fire) w_state_nxt = S_BUSY;
            S_BUSY:  if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    // Request capture at fire, latency countdown, result capture on the last BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_src1    <= '0;
            r_src2    <= '0;
            r_tag     <= '0;
            r_word    <= 1'b0;
            r_illegal <= 1'b0;
            r_result  <= '0;
        end else begin
            if (w_fire) begin
                r_cnt     <= CNT_W'(LATENCY - 1);
                r_op      <= w_op;
                r_src1    <= w_src1;
                r_src2    <= w_src2;
                r_tag     <= in_tag;
                r_word    <= in_word;
                r_illegal <= w_illegal;
            end else if (w_busy && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_last) begin
                if (r_illegal)   r_result <= '0;
                else if (r_word) r_result <= {{32{mac_result[31]}}, mac_result[31:0]};
                else             r_result <= mac_result;
            end
        end
    end

    assign mac_mul    = w_busy & r_op[0];
    assign mac_mulh   = w_busy & r_op[1];
    assign mac_mulhsu = w_busy & r_op[2];
    assign mac_mulhu  = w_busy & r_op[3];
    assign mac_div    = w_busy & r_op[4];
    assign mac_divu   = w_busy & r_op[5];
    assign mac_rem    = w_busy & r_op[6];
    assign mac_remu   = w_busy & r_op[7];
    assign mac_src1   = w_busy ? r_src1 : '0;
    assign mac_src2   = w_busy ? r_src2 : '0;

    assign out_valid   = (r_state == S_DONE);
    assign out_result  = r_result;
    assign out_tag     = r_tag;
    assign out_illegal = r_illegal;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: behavioural mul/div unit on the mac_* side,
// scoreboard of expected responses filled at request fire.
module tb_mdu_issue_ctrl;

    localparam int LAT = 4;
    localparam int TW  = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_funct3 = 3'd0;
    logic          in_word = 1'b0;
    logic [63:0]   in_src1 = '0;
    logic [63:0]   in_src2 = '0;
    logic [TW-1:0] in_tag = '0;
    logic          mac_mul, mac_mulh, mac_mulhu, mac_mulhsu;
    logic          mac_div, mac_divu, mac_rem, mac_remu;
    logic [63:0]   mac_src1, mac_src2;
    logic [63:0]   mac_result;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [63:0]   out_result;
    logic [TW-1:0] out_tag;
    logic          out_illegal;

    mdu_issue_ctrl #(.LATENCY(LAT), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_word(in_word), .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .mac_mul(mac_mul), .mac_mulh(mac_mulh), .mac_mulhu(mac_mulhu),
        .mac_mulhsu(mac_mulhsu), .mac_div(mac_div), .mac_divu(mac_divu),
        .mac_rem(mac_rem), .mac_remu(mac_remu),
        .mac_src1(mac_src1), .mac_src2(mac_src2), .mac_result(mac_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // RV64 M-extension semantics on full 64-bit operands.
    function automatic logic [63:0] alu(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic signed [63:0] sa, sb;
        sa = a;
        sb = b;
        case (f)
            3'd0: alu = a * b;
            3'd1: begin p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); alu = p[127:64]; end
            3'd2: begin p = $signed({{64{a[63]}}, a}) * $signed({64'h0, b}); alu = p[127:64]; end
            3'd3: begin p = {64'h0, a} * {64'h0, b}; alu = p[127:64]; end
            3'd4: alu = (b == 0) ? '1 : ((a == 64'h8000_0000_0000_0000 && b == '1) ? a : 64'(sa / sb));
            3'd5: alu = (b == 0) ? '1 : a / b;
            3'd6: alu = (b == 0) ? a : ((a == 64'h8000_0000_0000_0000 && b == '1) ? '0 : 64'(sa % sb));
            default: alu = (b == 0) ? a : a % b;
        endcase
    endfunction

    // Expected architectural rd value computed straight from the request.
    function automatic logic [63:0] expect_rd(input logic [2:0] f, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [63:0] ca, cb, r;
        if (w && (f == 3'd1 || f == 3'd2 || f == 3'd3)) return '0;
        ca = a;
        cb = b;
        if (w) begin
            if (f == 3'd5 || f == 3'd7) begin
                ca = {32'h0, a[31:0]};
                cb = {32'h0, b[31:0]};
            end else begin
                ca = {{32{a[31]}}, a[31:0]};
                cb = {{32{b[31]}}, b[31:0]};
            end
        end
        r = alu(f, ca, cb);
        return w ? {{32{r[31]}}, r[31:0]} : r;
    endfunction

    // Behavioural mul/div unit; poison value when no op line is asserted.
    always_comb begin
        mac_result = 64'hDEAD_BEEF_0BAD_F00D;
        if (mac_mul)    mac_result = alu(3'd0, mac_src1, mac_src2);
        if (mac_mulh)   mac_result = alu(3'd1, mac_src1, mac_src2);
        if (mac_mulhsu) mac_result = alu(3'd2, mac_src1, mac_src2);
        if (mac_mulhu)  mac_result = alu(3'd3, mac_src1, mac_src2);
        if (mac_div)    mac_result = alu(3'd4, mac_src1, mac_src2);
        if (mac_divu)   mac_result = alu(3'd5, mac_src1, mac_src2);
        if (mac_rem)    mac_result = alu(3'd6, mac_src1, mac_src2);
        if (mac_remu)   mac_result = alu(3'd7, mac_src1, mac_src2);
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0]   res;
        logic [TW-1:0] tag;
        logic          ill;
        int            fire_cyc;
    } exp_t;

    exp_t sb[$];
    logic prev_v = 1'b0;
    exp_t e;

    // Response monitor: latency on the rising edge of out_valid, data at handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v <= 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) chk("spurious_valid", 64'(out_valid), 64'd0);
                else                chk("latency", 64'(cyc - sb[0].fire_cyc), 64'(LAT));
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk("result", out_result, e.res);
                chk("tag", 64'(out_tag), 64'(e.tag));
                chk("illegal", 64'(out_illegal), 64'(e.ill));
            end
            prev_v <= out_valid;
        end
    end

    // Present a request; returns (at posedge+1) once it has fired, with the wait in cycles.
    task automatic issue(input logic [2:0] f, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [TW-1:0] t, output int waits);
        exp_t x;
        in_valid  = 1'b1;
        in_funct3 = f;
        in_word   = w;
        in_src1   = a;
        in_src2   = b;
        in_tag    = t;
        waits     = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                x.res      = expect_rd(f, w, a, b);
                x.tag      = t;
                x.ill      = w && (f == 3'd1 || f == 3'd2 || f == 3'd3);
                x.fire_cyc = cyc + 1;
                sb.push_back(x);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            waits++;
            @(posedge clk);
            #1;
        end
        chk("issue_timeout", 64'(waits), 64'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain(input logic rand_rdy);
        for (int i = 0; i < 300 && sb.size() > 0; i++) begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
        if (sb.size() > 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        out_ready = 1'b1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        chk("valid_timeout", 64'(out_valid), 64'd1);
    endtask

    logic [63:0] vals [8] = '{64'd0, 64'd1, 64'd5, '1, 64'h7FFF_FFFF,
                              64'h8000_0000, 64'h8000_0000_0000_0000, 64'h1234_5678_9ABC_DEF0};

    initial begin
        int w8;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_illegal", 64'(out_illegal), 64'd0);
        chk("rst_mac_ops", 64'({mac_mul, mac_mulh, mac_mulhu, mac_mulhsu,
                                 mac_div, mac_divu, mac_rem, mac_remu}), 64'd0);
        chk("rst_mac_src", mac_src1 | mac_src2, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // mulw overflowing into bit 31
        issue(3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd1, w8);
        drain(1'b0);

        // divw overflow case; operand conditioning visible on mac_src1
        issue(3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd2, w8);
        @(negedge clk);
        chk("divw_mac_src1", mac_src1, 64'hFFFF_FFFF_8000_0000);
        chk("divw_mac_src2", mac_src2, '1);
        chk("divw_mac_div", 64'(mac_div), 64'd1);
        drain(1'b0);

        // divide by zero, plain and word unsigned
        issue(3'd5, 1'b0, 64'd5, 64'd0, 5'd3, w8);
        drain(1'b0);
        issue(3'd7, 1'b1, 64'hFFFF_FFFF_0000_0007, 64'd0, 5'd4, w8);
        @(negedge clk);
        chk("remuw_mac_src1", mac_src1, 64'd7);
        drain(1'b0);

        // mulh with 10 cycles of back-pressure
        out_ready = 1'b0;
        issue(3'd1, 1'b0, '1, '1, 5'd5, w8);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_result", out_result, 64'd0);
            chk("bp_tag", 64'(out_tag), 64'd5);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain(1'b0);

        // flush on the second BUSY cycle, with a request offered in the flush cycle
        issue(3'd0, 1'b0, 64'd3, 64'd4, 5'd6, w8);
        @(posedge clk);
        #1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_tag    = 5'd9;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_idle_ready", 64'(in_ready), 64'd1);
        chk("flush_no_valid", 64'(out_valid), 64'd0);
        chk("flush_mac_idle", 64'(mac_mul), 64'd0);
        @(posedge clk);
        #1;
        issue(3'd6, 1'b0, 64'd17, 64'd5, 5'd12, w8);
        chk("flush_refire_wait", 64'(w8), 64'd0);
        drain(1'b0);

        // illegal word form of mulh
        issue(3'd1, 1'b1, 64'd3, 64'd3, 5'd13, w8);
        @(negedge clk);
        chk("ill_mac_ops", 64'({mac_mul, mac_mulh, mac_mulhu, mac_mulhsu,
                                mac_div, mac_divu, mac_rem, mac_remu}), 64'd0);
        drain(1'b0);

        // reset while holding a response in DONE
        out_ready = 1'b0;
        issue(3'd0, 1'b0, 64'd6, 64'd7, 5'd14, w8);
        wait_valid();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_done_valid", 64'(out_valid), 64'd0);
        chk("rst_done_result", out_result, 64'd0);
        chk("rst_done_tag", 64'(out_tag), 64'd0);
        chk("rst_done_ready", 64'(in_ready), 64'd1);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // random mix with random write-back back-pressure
        for (int i = 0; i < 24; i++) begin
            issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  vals[$urandom_range(0, 7)] ^ 64'($urandom_range(0, 3)),
                  vals[$urandom_range(0, 7)], 5'($urandom_range(0, 31)), w8);
            drain(1'b1);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
